// File: rtl/sdx_kernel_addwm_example_subtractor.sv
// sdx_kernel_addwm_example_subtractor: per-lane watermark-constant removal on an AXI-Stream,
// with a two-entry skid buffer, packet-locked constant and beat/packet/keep status counters.
module sdx_kernel_addwm_example_subtractor #(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_ADDER_BIT_WIDTH  = 32,
  parameter int C_COUNT_WIDTH      = 32
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [C_ADDER_BIT_WIDTH-1:0]    ctrl_constant,
  input  logic                            ctrl_clear,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                            s_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                            m_axis_tlast,
  output logic [C_COUNT_WIDTH-1:0]        stat_beats,
  output logic [C_COUNT_WIDTH-1:0]        stat_pkts,
  output logic                            stat_keep_err
);
  localparam int W  = C_AXIS_TDATA_WIDTH;
  localparam int A  = C_ADDER_BIT_WIDTH;
  localparam int KW = W / 8;
  localparam int N  = W / A;
  typedef struct packed {
    logic [W-1:0]  data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;
  typedef enum logic {IDLE, PKT} state_t;
  state_t state_q, state_d;
  beat_t out_q, out_d, skid_q, skid_d, in_b;
  logic [A-1:0] const_q, const_d;
  logic ov_q, ov_d, sv_q, sv_d, rdy_q, rdy_d;
  logic [C_COUNT_WIDTH-1:0] beats_q, beats_d, pkts_q, pkts_d;
  logic err_q, err_d;
  logic acc, take;
  logic [W-1:0] sub;
  for (genvar i = 0; i < N; i++) begin : g_lane
    assign sub[i*A +: A] = s_axis_tdata[i*A +: A] - const_q;
  end
  assign in_b = {sub, s_axis_tkeep, s_axis_tlast};
  assign acc  = s_axis_tvalid & rdy_q;
  assign take = ov_q & m_axis_tready;
  // Skid is only ever full while rdy_q is low, so a new beat never meets a full skid.
  always_comb begin
    out_d  = out_q;
    skid_d = skid_q;
    ov_d   = ov_q;
    sv_d   = sv_q;
    if (sv_q) begin
      if (take) begin
        out_d = skid_q;
        sv_d  = 1'b0;
      end
    end else if (acc) begin
      if (!ov_q || take) begin
        out_d = in_b;
        ov_d  = 1'b1;
      end else begin
        skid_d = in_b;
        sv_d   = 1'b1;
      end
    end else if (take) begin
      ov_d = 1'b0;
    end
    rdy_d   = !sv_d;
    state_d = acc ? (s_axis_tlast ? IDLE : PKT) : state_q;
    const_d = (state_q == IDLE && !acc) ? ctrl_constant : const_q;
    beats_d = ctrl_clear ? '0 : beats_q + {{(C_COUNT_WIDTH-1){1'b0}}, acc};
    pkts_d  = ctrl_clear ? '0 : pkts_q + {{(C_COUNT_WIDTH-1){1'b0}}, acc & s_axis_tlast};
    err_d   = ctrl_clear ? 1'b0 : err_q | (acc & !s_axis_tlast & ~&s_axis_tkeep);
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      out_q   <= '0;
      skid_q  <= '0;
      ov_q    <= 1'b0;
      sv_q    <= 1'b0;
      rdy_q   <= 1'b0;
      const_q <= '0;
      beats_q <= '0;
      pkts_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      ov_q    <= ov_d;
      sv_q    <= sv_d;
      rdy_q   <= rdy_d;
      const_q <= const_d;
      beats_q <= beats_d;
      pkts_q  <= pkts_d;
      err_q   <= err_d;
    end
  end
  assign s_axis_tready = rdy_q;
  assign m_axis_tvalid = ov_q;
  assign m_axis_tdata  = out_q.data;
  assign m_axis_tkeep  = out_q.keep;
  assign m_axis_tlast  = out_q.last;
  assign stat_beats    = beats_q;
  assign stat_pkts     = pkts_q;
  assign stat_keep_err = err_q;
endmodule

// File: tb/tb_sdx_kernel_addwm_example_subtractor.sv
// tb_sdx_kernel_addwm_example_subtractor: directed vector table plus hand-written
// packet, backpressure, clear and reset sequences for the watermark subtractor.
module tb_sdx_kernel_addwm_example_subtractor;
  localparam int W  = 512;
  localparam int A  = 32;
  localparam int N  = W / A;
  localparam int KW = W / 8;
  localparam int CW = 32;
  typedef struct {
    logic [31:0]   c;
    logic [31:0]   a;
    logic [31:0]   s;
    logic [31:0]   e;
    logic [KW-1:0] keep;
  } vec_t;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic [A-1:0] ctrl_constant;
  logic ctrl_clear;
  logic s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [W-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [W-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [CW-1:0] stat_beats, stat_pkts;
  logic stat_keep_err;
  int checks = 0;
  int failures = 0;
  localparam logic [KW-1:0] ALL = '1;
  localparam logic [KW-1:0] BAD = {4'h0, {(KW-4){1'b1}}};
  sdx_kernel_addwm_example_subtractor dut (
    .aclk(aclk), .aresetn(aresetn), .ctrl_constant(ctrl_constant), .ctrl_clear(ctrl_clear),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .stat_beats(stat_beats), .stat_pkts(stat_pkts), .stat_keep_err(stat_keep_err)
  );
  always #5 aclk = ~aclk;
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [W-1:0] rep(input logic [31:0] a, input logic [31:0] s);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*A +: A] = a + s * 32'(i);
    return r;
  endfunction
  task automatic step;
    @(posedge aclk);
    @(negedge aclk);
  endtask
  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] s,
                       input logic [KW-1:0] keep, input logic last);
    s_axis_tvalid = v;
    s_axis_tdata  = v ? rep(a, s) : '0;
    s_axis_tkeep  = v ? keep : '0;
    s_axis_tlast  = v & last;
  endtask
  vec_t v[6];
  initial begin
    v[0] = '{c: 32'h10,       a: 32'h25,       s: 32'h0,        e: 32'h15,       keep: ALL};
    v[1] = '{c: 32'h10,       a: 32'h5,        s: 32'h0,        e: 32'hFFFFFFF5, keep: ALL};
    v[2] = '{c: 32'h0,        a: 32'hDEADBEEF, s: 32'h01010101, e: 32'hDEADBEEF, keep: 64'h00FF_00FF_00FF_00FF};
    v[3] = '{c: 32'hFFFFFFFF, a: 32'h0,        s: 32'h1,        e: 32'h1,        keep: BAD};
    v[4] = '{c: 32'h12345678, a: 32'h12345678, s: 32'h100,      e: 32'h0,        keep: 64'h1};
    v[5] = '{c: 32'h80000000, a: 32'h7FFFFFFF, s: 32'h0,        e: 32'hFFFFFFFF, keep: ALL};
    ctrl_constant = '0;
    ctrl_clear    = 1'b0;
    m_axis_tready = 1'b1;
    drive(1'b0, 0, 0, '0, 1'b0);
    @(negedge aclk);
    @(negedge aclk);
    chk("rst_mvalid", m_axis_tvalid, 0);
    chk("rst_sready", s_axis_tready, 0);
    chk("rst_mdata", m_axis_tdata, 0);
    chk("rst_beats", stat_beats, 0);
    chk("rst_pkts", stat_pkts, 0);
    chk("rst_err", stat_keep_err, 0);
    aresetn = 1'b1;
    #1 chk("rel_sready_low", s_axis_tready, 0);
    @(negedge aclk);
    chk("rel_sready_high", s_axis_tready, 1);
    for (int k = 0; k < 6; k++) begin
      ctrl_constant = v[k].c;
      drive(1'b0, 0, 0, '0, 1'b0);
      step();
      drive(1'b1, v[k].a, v[k].s, v[k].keep, 1'b1);
      step();
      drive(1'b0, 0, 0, '0, 1'b0);
      chk($sformatf("vec%0d_valid", k), m_axis_tvalid, 1);
      chk($sformatf("vec%0d_data", k), m_axis_tdata, rep(v[k].e, v[k].s));
      chk($sformatf("vec%0d_keep", k), m_axis_tkeep, v[k].keep);
      chk($sformatf("vec%0d_last", k), m_axis_tlast, 1);
      if (k == 0) begin
        chk("vec0_beats", stat_beats, 1);
        chk("vec0_pkts", stat_pkts, 1);
      end
    end
    step();
    chk("tbl_drained", m_axis_tvalid, 0);
    chk("tbl_beats", stat_beats, 6);
    chk("tbl_pkts", stat_pkts, 6);
    chk("tbl_err", stat_keep_err, 0);
    ctrl_constant = 32'h10;
    step();
    drive(1'b1, 32'h100, 0, ALL, 1'b0);
    step();
    chk("lock_b1", m_axis_tdata, rep(32'hF0, 0));
    ctrl_constant = 32'h20;
    drive(1'b1, 32'h200, 0, ALL, 1'b0);
    step();
    chk("lock_b2", m_axis_tdata, rep(32'h1F0, 0));
    drive(1'b1, 32'h300, 0, ALL, 1'b1);
    step();
    chk("lock_b3", m_axis_tdata, rep(32'h2F0, 0));
    chk("lock_b3_last", m_axis_tlast, 1);
    drive(1'b0, 0, 0, '0, 1'b0);
    step();
    drive(1'b1, 32'h300, 0, ALL, 1'b1);
    step();
    chk("lock_next", m_axis_tdata, rep(32'h2E0, 0));
    drive(1'b0, 0, 0, '0, 1'b0);
    step();
    chk("lock_beats", stat_beats, 10);
    chk("lock_pkts", stat_pkts, 8);
    begin
      int sent, recv, cyc;
      bit stall, acc, tk;
      sent = 0; recv = 0; cyc = 0; stall = 0;
      while (recv < 4 && cyc < 40) begin
        m_axis_tready = !(cyc inside {[1:3]});
        if (sent < 4) drive(1'b1, 32'h1000 * 32'(sent + 1), 1, ALL, sent == 3);
        else drive(1'b0, 0, 0, '0, 1'b0);
        acc = s_axis_tvalid && s_axis_tready;
        tk  = m_axis_tvalid && m_axis_tready;
        if (!s_axis_tready) stall = 1;
        if (m_axis_tvalid && recv < 4)
          chk($sformatf("bp_data%0d", recv), m_axis_tdata, rep(32'h1000 * 32'(recv + 1) - 32'h20, 1));
        @(posedge aclk);
        sent += int'(acc);
        recv += int'(tk);
        @(negedge aclk);
        cyc++;
      end
      chk("bp_recv", 32'(recv), 4);
      chk("bp_stall", {31'b0, stall}, 1);
    end
    m_axis_tready = 1'b1;
    drive(1'b0, 0, 0, '0, 1'b0);
    step();
    chk("bp_beats", stat_beats, 14);
    chk("bp_pkts", stat_pkts, 9);
    drive(1'b1, 0, 0, BAD, 1'b0);
    step();
    chk("kerr_set", stat_keep_err, 1);
    drive(1'b1, 0, 0, ALL, 1'b1);
    step();
    drive(1'b0, 0, 0, '0, 1'b0);
    chk("kerr_sticky", stat_keep_err, 1);
    chk("kerr_beats", stat_beats, 16);
    chk("kerr_pkts", stat_pkts, 10);
    ctrl_clear = 1'b1;
    drive(1'b1, 0, 0, BAD, 1'b0);
    step();
    ctrl_clear = 1'b0;
    drive(1'b0, 0, 0, '0, 1'b0);
    chk("clr_beats", stat_beats, 0);
    chk("clr_pkts", stat_pkts, 0);
    chk("clr_err", stat_keep_err, 0);
    chk("clr_data", m_axis_tdata, rep(32'hFFFFFFE0, 0));
    drive(1'b1, 0, 0, ALL, 1'b1);
    step();
    drive(1'b0, 0, 0, '0, 1'b0);
    chk("post_clr_beats", stat_beats, 1);
    chk("post_clr_pkts", stat_pkts, 1);
    m_axis_tready = 1'b0;
    drive(1'b1, 32'h5000, 0, ALL, 1'b0);
    step();
    drive(1'b1, 32'h6000, 0, ALL, 1'b0);
    step();
    drive(1'b0, 0, 0, '0, 1'b0);
    chk("full_sready", s_axis_tready, 0);
    chk("full_mvalid", m_axis_tvalid, 1);
    aresetn = 1'b0;
    #1;
    chk("arst_mvalid", m_axis_tvalid, 0);
    chk("arst_sready", s_axis_tready, 0);
    chk("arst_beats", stat_beats, 0);
    chk("arst_mdata", m_axis_tdata, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    m_axis_tready = 1'b1;
    step();
    chk("arel_sready", s_axis_tready, 1);
    chk("arel_mvalid", m_axis_tvalid, 0);
    drive(1'b1, 32'h100, 0, ALL, 1'b1);
    step();
    drive(1'b0, 0, 0, '0, 1'b0);
    chk("arel_idle_data", m_axis_tdata, rep(32'hE0, 0));
    chk("arel_beats", stat_beats, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
